ld_st_control_sequencer: RTL and testbench
==========================================

// Module: ld_st_control_sequencer
// PURPOSE
//  Moore control FSM driving Datapath control inputs for ld, ldi and st (fetch + execute).
//  Replaces hand-driven control sequencing; sits between top-level run/IR and Datapath.
//  Emits one control vector per state, plus a done pulse and a retired-instruction count.
// PARAMETERS
//  OPC_LD   5'b00000  opcode ld  (Ra <= M[Rb+C], Rb=R0 means base 0 via BAout)
//  OPC_LDI  5'b00001  opcode ldi (Ra <= Rb+C)
//  OPC_ST   5'b00010  opcode st  (M[Rb+C] <= Ra)
//  CNT_W    16        width of instr_count
// PORTS
//  clk           in   1      system clock, all state updates on rising edge
//  clr           in   1      synchronous active-high reset
//  run           in   1      start/continue; sampled in IDLE and in last execute state
//  IRdataout     in   32     IR contents from Datapath; opcode = IRdataout[31:27]
//  PCout,MARin,IncPC,Zin,Zlowout,PCin,Read,Write,MDRin,MDRout   out 1 each  datapath controls
//  IRin,BAout,Yin,ADD,Rin,Rout,Gra,Grb,Cout                     out 1 each  datapath controls
//  done          out  1      1-cycle pulse in final state of a legal instruction
//  illegal       out  1      1-cycle pulse when decoded opcode not ld/ldi/st
//  instr_count   out  CNT_W  retired legal instructions, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Outputs decoded from state register only (no input->output paths); unlisted controls = 0.
//  clr=1 at a rising edge: state<=IDLE, instr_count<=0, op latch<=0; all outputs 0 next cycle.
//  clr mid-instruction aborts immediately; a partial memory Write is never re-asserted.
//  IDLE: all 0; run=1 -> T0 else stay.  PCin never asserted (no branches here).
//  T0: PCout,MARin,IncPC           -> T1
//  T1: Read,MDRin                  -> T2
//  T2: MDRout,IRin                 -> T3
//  T3: Grb,BAout,Yin; latch IRdataout[31:27]; legal -> T4, else illegal=1 -> IDLE
//  T4: Cout,ADD,Zin                -> T5
//  T5 ldi: Zlowout,Gra,Rin,done (last).  T5 ld/st: Zlowout,MARin -> T6
//  T6 ld: Read,MDRin -> T7.   T6 st: Gra,Rout,MDRin (Read=0, MDR loads bus) -> T7
//  T7 ld: MDRout,Gra,Rin,done (last).   T7 st: Write,done (last)
//  Last state: instr_count+=1 at that edge; run=1 -> T0 (back-to-back, no IDLE bubble), else IDLE.
//  Latency: ldi 6 cycles T0..T5, ld/st 8 cycles T0..T7; +1 from IDLE on first run.
//  Opcode latched in T3 used for T5..T7; IRdataout changes after T3 ignored.
//  Read and Write never both 1; Gra and Grb never both 1; single bus driver per state.
//  State encoding implementer's choice; unreachable encodings -> IDLE.
// CONFIGURATION
//  MEM_WAIT_EN defined: adds input mem_ready (1 bit). States T1, ld-T6 and st-T7 hold,
//   controls asserted, until mem_ready=1 at a rising edge, then advance normally;
//   done in st-T7 only in the cycle mem_ready=1; clr overrides the wait.
//  MEM_WAIT_EN undefined: no mem_ready port; every memory state is exactly 1 cycle.
// TESTING
//  clr=1 2 cycles, run=0 -> all controls 0, done=0, instr_count=0, FSM in IDLE.
//  IR=32'h00080045 (ld R0,$45(R1)), run pulsed 1 cycle -> T0..T7 control vectors as above,
//   done=1 in T7 only, instr_count=1, IDLE afterward.
//  IR=32'h08080045 (ldi R0,$45(R1)) -> T5 shows Zlowout,Gra,Rin,done; 6 cycles; count+1.
//  IR=32'h10080045 (st $45(R1),R0), run held 1 -> T6 Gra,Rout,MDRin; T7 Write=1,Read=0;
//   next cycle T0 directly (no IDLE); instr_count increments every 8 cycles.
//  IR=32'hF8000000 -> illegal=1 one cycle after T3, IDLE, instr_count unchanged.
//  clr asserted during ld T6 -> all outputs 0 next cycle, instr_count=0; with MEM_WAIT_EN
//   and mem_ready=0 for 3 cycles in T1 -> T1 controls held 4 cycles, then T2.

Source files
------------

// File: rtl/ld_st_control_sequencer.sv
// Moore control sequencer for ld/ldi/st fetch+execute driving the Datapath control lines.
// Optional build macro MEM_WAIT_EN adds a mem_ready handshake that stretches memory states.
module ld_st_control_sequencer #(
    parameter logic [4:0]  OPC_LD  = 5'b00000,
    parameter logic [4:0]  OPC_LDI = 5'b00001,
    parameter logic [4:0]  OPC_ST  = 5'b00010,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
`ifdef MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    input  logic [31:0]      IRdataout,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             Read,
    output logic             Write,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             BAout,
    output logic             Yin,
    output logic             ADD,
    output logic             Rin,
    output logic             Rout,
    output logic             Gra,
    output logic             Grb,
    output logic             Cout,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;

    localparam logic [19:0] M_PCOUT   = 20'd1 << 0;
    localparam logic [19:0] M_MARIN   = 20'd1 << 1;
    localparam logic [19:0] M_INCPC   = 20'd1 << 2;
    localparam logic [19:0] M_ZIN     = 20'd1 << 3;
    localparam logic [19:0] M_ZLOWOUT = 20'd1 << 4;
    localparam logic [19:0] M_PCIN    = 20'd1 << 5;
    localparam logic [19:0] M_READ    = 20'd1 << 6;
    localparam logic [19:0] M_WRITE   = 20'd1 << 7;
    localparam logic [19:0] M_MDRIN   = 20'd1 << 8;
    localparam logic [19:0] M_MDROUT  = 20'd1 << 9;
    localparam logic [19:0] M_IRIN    = 20'd1 << 10;
    localparam logic [19:0] M_BAOUT   = 20'd1 << 11;
    localparam logic [19:0] M_YIN     = 20'd1 << 12;
    localparam logic [19:0] M_ADD     = 20'd1 << 13;
    localparam logic [19:0] M_RIN     = 20'd1 << 14;
    localparam logic [19:0] M_ROUT    = 20'd1 << 15;
    localparam logic [19:0] M_GRA     = 20'd1 << 16;
    localparam logic [19:0] M_GRB     = 20'd1 << 17;
    localparam logic [19:0] M_COUT    = 20'd1 << 18;
    localparam logic [19:0] M_DONE    = 20'd1 << 19;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [4:0]       r_op;
    logic [19:0]      r_ctrl;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       w_state_nxt;
    logic [4:0]       w_op_nxt;
    logic [4:0]       w_ir_op;
    logic             w_legal;
    logic             w_is_last;
    logic             w_hold;
    logic             w_retire;
    logic             w_unused_ir;

    // Control vector for a given state; PCin is never set since no branches are sequenced.
    function automatic logic [19:0] decode_ctrl(input logic [3:0] st, input logic [4:0] op);
        logic [19:0] v;
        v = 20'd0;
        case (st)
            S_T0:    v = M_PCOUT | M_MARIN | M_INCPC;
            S_T1:    v = M_READ | M_MDRIN;
            S_T2:    v = M_MDROUT | M_IRIN;
            S_T3:    v = M_GRB | M_BAOUT | M_YIN;
            S_T4:    v = M_COUT | M_ADD | M_ZIN;
            S_T5:    v = (op == OPC_LDI) ? (M_ZLOWOUT | M_GRA | M_RIN | M_DONE)
                                         : (M_ZLOWOUT | M_MARIN);
            S_T6:    v = (op == OPC_LD) ? (M_READ | M_MDRIN)
                       : (op == OPC_ST) ? (M_GRA | M_ROUT | M_MDRIN) : 20'd0;
            S_T7:    v = (op == OPC_LD) ? (M_MDROUT | M_GRA | M_RIN | M_DONE)
                       : (op == OPC_ST) ? (M_WRITE | M_DONE) : 20'd0;
            default: v = 20'd0;
        endcase
        return v;
    endfunction

    assign w_ir_op     = IRdataout[31:27];
    assign w_unused_ir = ^IRdataout[26:0];
    assign w_legal     = (w_ir_op == OPC_LD) || (w_ir_op == OPC_LDI) || (w_ir_op == OPC_ST);
    assign w_is_last   = ((r_state == S_T5) && (r_op == OPC_LDI)) || (r_state == S_T7);
    assign w_retire    = w_is_last && !w_hold;

`ifdef MEM_WAIT_EN
    assign w_hold = !mem_ready && ((r_state == S_T1) ||
                                   ((r_state == S_T6) && (r_op == OPC_LD)) ||
                                   ((r_state == S_T7) && (r_op == OPC_ST)));
    // A stalled store only signals completion in the cycle memory accepts it.
    assign done   = r_ctrl[19] && !((r_state == S_T7) && (r_op == OPC_ST) && !mem_ready);
`else
    assign w_hold = 1'b0;
    assign done   = r_ctrl[19];
`endif

    // Opcode is captured at the end of T3 and frozen for the execute states.
    always_comb begin
        w_op_nxt = r_op;
        if (r_state == S_T3) begin
            w_op_nxt = w_ir_op;
        end else begin
            w_op_nxt = r_op;
        end
    end

    // Next-state sequencing; last states re-enter T0 directly while run stays high.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_hold) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = run ? S_T0 : S_IDLE;
                S_T0:    w_state_nxt = S_T1;
                S_T1:    w_state_nxt = S_T2;
                S_T2:    w_state_nxt = S_T3;
                S_T3:    w_state_nxt = w_legal ? S_T4 : S_IDLE;
                S_T4:    w_state_nxt = S_T5;
                S_T5:    w_state_nxt = (r_op == OPC_LDI) ? (run ? S_T0 : S_IDLE) : S_T6;
                S_T6:    w_state_nxt = S_T7;
                S_T7:    w_state_nxt = run ? S_T0 : S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, opcode latch, registered control vector, illegal pulse and retire counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_op      <= 5'd0;
            r_ctrl    <= 20'd0;
            r_illegal <= 1'b0;
            r_count   <= {CNT_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_ctrl    <= decode_ctrl(w_state_nxt, w_op_nxt);
            r_illegal <= (r_state == S_T3) && !w_legal;
            if (w_retire) begin
                r_count <= r_count + CNT_ONE;
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign PCout       = r_ctrl[0];
    assign MARin       = r_ctrl[1];
    assign IncPC       = r_ctrl[2];
    assign Zin         = r_ctrl[3];
    assign Zlowout     = r_ctrl[4];
    assign PCin        = r_ctrl[5];
    assign Read        = r_ctrl[6];
    assign Write       = r_ctrl[7];
    assign MDRin       = r_ctrl[8];
    assign MDRout      = r_ctrl[9];
    assign IRin        = r_ctrl[10];
    assign BAout       = r_ctrl[11];
    assign Yin         = r_ctrl[12];
    assign ADD         = r_ctrl[13];
    assign Rin         = r_ctrl[14];
    assign Rout        = r_ctrl[15];
    assign Gra         = r_ctrl[16];
    assign Grb         = r_ctrl[17];
    assign Cout        = r_ctrl[18];
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_ld_st_control_sequencer.sv
// Directed + randomized bench for ld_st_control_sequencer against a per-instruction cycle table.
module tb_ld_st_control_sequencer;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b00010;

    localparam logic [18:0] M_PCOUT   = 19'd1 << 18;
    localparam logic [18:0] M_MARIN   = 19'd1 << 17;
    localparam logic [18:0] M_INCPC   = 19'd1 << 16;
    localparam logic [18:0] M_ZIN     = 19'd1 << 15;
    localparam logic [18:0] M_ZLOWOUT = 19'd1 << 14;
    localparam logic [18:0] M_READ    = 19'd1 << 12;
    localparam logic [18:0] M_WRITE   = 19'd1 << 11;
    localparam logic [18:0] M_MDRIN   = 19'd1 << 10;
    localparam logic [18:0] M_MDROUT  = 19'd1 << 9;
    localparam logic [18:0] M_IRIN    = 19'd1 << 8;
    localparam logic [18:0] M_BAOUT   = 19'd1 << 7;
    localparam logic [18:0] M_YIN     = 19'd1 << 6;
    localparam logic [18:0] M_ADD     = 19'd1 << 5;
    localparam logic [18:0] M_RIN     = 19'd1 << 4;
    localparam logic [18:0] M_ROUT    = 19'd1 << 3;
    localparam logic [18:0] M_GRA     = 19'd1 << 2;
    localparam logic [18:0] M_GRB     = 19'd1 << 1;
    localparam logic [18:0] M_COUT    = 19'd1 << 0;

    localparam logic [18:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC;
    localparam logic [18:0] V_T1 = M_READ | M_MDRIN;
    localparam logic [18:0] V_T2 = M_MDROUT | M_IRIN;
    localparam logic [18:0] V_T3 = M_GRB | M_BAOUT | M_YIN;
    localparam logic [18:0] V_T4 = M_COUT | M_ADD | M_ZIN;

    logic        clk;
    logic        clr;
    logic        run;
    logic [31:0] IRdataout;
    logic        mem_ready;
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout;
    logic IRin, BAout, Yin, ADD, Rin, Rout, Gra, Grb, Cout, done, illegal;
    logic [15:0] instr_count;
    logic [18:0] obs;

    int          total;
    int          bad;
    logic [15:0] exp_cnt;
    logic [31:0] ir;
    logic        chain;
    int          sel;

    ld_st_control_sequencer dut (
        .clk(clk), .clr(clr), .run(run),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .IRdataout(IRdataout),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .PCin(PCin), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .BAout(BAout), .Yin(Yin), .ADD(ADD), .Rin(Rin), .Rout(Rout),
        .Gra(Gra), .Grb(Grb), .Cout(Cout), .done(done), .illegal(illegal),
        .instr_count(instr_count)
    );

    assign obs = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
                  IRin, BAout, Yin, ADD, Rin, Rout, Gra, Grb, Cout};

    always #5 clk = ~clk;

    // One clock, then compare controls, pulses and retire count at the falling edge.
    task automatic tick(input logic [18:0] ev, input logic ed, input logic ei, input string tag);
        @(posedge clk);
        @(negedge clk);
        total++;
        assert (obs === ev) else begin
            bad++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, ev);
        end
        total++;
        assert ({done, illegal} === {ed, ei}) else begin
            bad++;
            $error("FAIL %s done/illegal observed=%b expected=%b", tag, {done, illegal}, {ed, ei});
        end
        total++;
        assert (instr_count === exp_cnt) else begin
            bad++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, instr_count, exp_cnt);
        end
    endtask

    // Issue one instruction from IDLE or a back-to-back last state; run_end is run after T0.
    task automatic instr(input logic [31:0] ir_v, input logic run_end, input string tag);
        logic [4:0] op;
        op        = ir_v[31:27];
        IRdataout = ir_v;
        run       = 1'b1;
        tick(V_T0, 1'b0, 1'b0, {tag, "_T0"});
        run = run_end;
        tick(V_T1, 1'b0, 1'b0, {tag, "_T1"});
        tick(V_T2, 1'b0, 1'b0, {tag, "_T2"});
        tick(V_T3, 1'b0, 1'b0, {tag, "_T3"});
        if (op != OP_LD && op != OP_LDI && op != OP_ST) begin
            tick(19'd0, 1'b0, 1'b1, {tag, "_ILL"});
            return;
        end
        tick(V_T4, 1'b0, 1'b0, {tag, "_T4"});
        IRdataout = $urandom;
        if (op == OP_LDI) begin
            tick(M_ZLOWOUT | M_GRA | M_RIN, 1'b1, 1'b0, {tag, "_T5"});
        end else begin
            tick(M_ZLOWOUT | M_MARIN, 1'b0, 1'b0, {tag, "_T5"});
            if (op == OP_LD) begin
                tick(M_READ | M_MDRIN, 1'b0, 1'b0, {tag, "_T6"});
                tick(M_MDROUT | M_GRA | M_RIN, 1'b1, 1'b0, {tag, "_T7"});
            end else begin
                tick(M_GRA | M_ROUT | M_MDRIN, 1'b0, 1'b0, {tag, "_T6"});
                tick(M_WRITE, 1'b1, 1'b0, {tag, "_T7"});
            end
        end
        exp_cnt = exp_cnt + 16'd1;
    endtask

    initial begin
        clk       = 1'b0;
        clr       = 1'b1;
        run       = 1'b0;
        IRdataout = 32'd0;
        mem_ready = 1'b1;
        total     = 0;
        bad       = 0;
        exp_cnt   = 16'd0;

        tick(19'd0, 1'b0, 1'b0, "reset0");
        tick(19'd0, 1'b0, 1'b0, "reset1");
        clr = 1'b0;
        tick(19'd0, 1'b0, 1'b0, "idle0");
        tick(19'd0, 1'b0, 1'b0, "idle1");

        instr(32'h00080045, 1'b0, "ld");
        tick(19'd0, 1'b0, 1'b0, "ld_idle");
        tick(19'd0, 1'b0, 1'b0, "ld_idle2");

        instr(32'h08080045, 1'b0, "ldi");
        tick(19'd0, 1'b0, 1'b0, "ldi_idle");

        instr(32'h10080045, 1'b1, "st_a");
        instr(32'h10080045, 1'b1, "st_b");
        instr(32'h10080045, 1'b0, "st_c");
        tick(19'd0, 1'b0, 1'b0, "st_idle");

        instr(32'hF8000000, 1'b0, "bad_op");
        tick(19'd0, 1'b0, 1'b0, "bad_idle");

        IRdataout = 32'h00080045;
        run       = 1'b1;
        tick(V_T0, 1'b0, 1'b0, "abort_T0");
        run = 1'b0;
        tick(V_T1, 1'b0, 1'b0, "abort_T1");
        tick(V_T2, 1'b0, 1'b0, "abort_T2");
        tick(V_T3, 1'b0, 1'b0, "abort_T3");
        tick(V_T4, 1'b0, 1'b0, "abort_T4");
        tick(M_ZLOWOUT | M_MARIN, 1'b0, 1'b0, "abort_T5");
        tick(M_READ | M_MDRIN, 1'b0, 1'b0, "abort_T6");
        clr     = 1'b1;
        exp_cnt = 16'd0;
        tick(19'd0, 1'b0, 1'b0, "abort_clr");
        clr = 1'b0;
        tick(19'd0, 1'b0, 1'b0, "abort_idle");

`ifdef MEM_WAIT_EN
        IRdataout = 32'h00080045;
        run       = 1'b1;
        tick(V_T0, 1'b0, 1'b0, "wait_T0");
        run       = 1'b0;
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(V_T1, 1'b0, 1'b0, "wait_T1");
        end
        mem_ready = 1'b1;
        tick(V_T2, 1'b0, 1'b0, "wait_T2");
        tick(V_T3, 1'b0, 1'b0, "wait_T3");
        tick(V_T4, 1'b0, 1'b0, "wait_T4");
        tick(M_ZLOWOUT | M_MARIN, 1'b0, 1'b0, "wait_T5");
        tick(M_READ | M_MDRIN, 1'b0, 1'b0, "wait_T6");
        tick(M_MDROUT | M_GRA | M_RIN, 1'b1, 1'b0, "wait_T7");
        exp_cnt = exp_cnt + 16'd1;
        tick(19'd0, 1'b0, 1'b0, "wait_idle");
`endif

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            ir  = $urandom;
            case (sel)
                0:       ir[31:27] = OP_LD;
                1:       ir[31:27] = OP_LDI;
                2:       ir[31:27] = OP_ST;
                default: ir[31:27] = 5'd3 + 5'($urandom_range(0, 28));
            endcase
            chain = (n != 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            instr(ir, chain, "rnd");
            if (!chain) begin
                run = 1'b0;
                tick(19'd0, 1'b0, 1'b0, "rnd_idle");
            end
        end

        run = 1'b0;
        tick(19'd0, 1'b0, 1'b0, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
